// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Build option: define REGFILE_ARB_DBG_EN to enable the debug write port.
package regfile_write_arbiter_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int ACC_ADDR = NUM_REGS - 1;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LD   = 2'd1,
        REQ_DBG  = 2'd2,
        REQ_NONE = 2'd3
    } req_id_e;

    // One-hot register mask, all zero when not enabled
    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr,
                                                        input logic              en);
        return en ? (NUM_REGS'(1) << addr) : '0;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester, decoder claim and register-file write port bundle.
// The dbg_* group is always present; it is only acted on when REGFILE_ARB_DBG_EN is defined.
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ready;

    logic              claim_en;
    logic [ADDR_W-1:0] claim_addr;

    logic                rf_write_en;
    logic [ADDR_W-1:0]   rf_write_addr;
    logic [DATA_W-1:0]   rf_write_data;
    logic [NUM_REGS-1:0] busy;
    logic                acc_busy;
    logic                claim_conflict;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  dbg_valid, dbg_addr, dbg_data,
        input  claim_en, claim_addr,
        output alu_ready, ld_ready, dbg_ready,
        output rf_write_en, rf_write_addr, rf_write_data,
        output busy, acc_busy, claim_conflict
    );

    // Requester / decoder / register-file side
    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output dbg_valid, dbg_addr, dbg_data,
        output claim_en, claim_addr,
        input  alu_ready, ld_ready, dbg_ready,
        input  rf_write_en, rf_write_addr, rf_write_data,
        input  busy, acc_busy, claim_conflict
    );

endinterface

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Per-register pending-write tracker. A claim marks a register pending, an
// architectural writeback clears it; a claim on an already pending register
// (not being cleared in the same cycle) raises a one-cycle conflict pulse.
module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_claim_en,
    input  logic [ADDR_W-1:0]   i_claim_addr,
    input  logic                i_clr_en,
    input  logic [ADDR_W-1:0]   i_clr_addr,
    output logic [NUM_REGS-1:0] o_busy,
    output logic                o_claim_conflict
);

    logic [NUM_REGS-1:0] r_busy;
    logic                r_conflict;
    logic [NUM_REGS-1:0] w_claim_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_conflict;

    // Clear first, then claim: a same-cycle claim keeps the register pending
    always_comb begin
        w_claim_mask = addr_onehot(i_claim_addr, i_claim_en);
        w_clr_mask   = addr_onehot(i_clr_addr, i_clr_en);
        w_busy_next  = (r_busy & ~w_clr_mask) | w_claim_mask;
        w_conflict   = i_claim_en & r_busy[i_claim_addr] & ~w_clr_mask[i_claim_addr];
    end

    // Busy vector and registered conflict pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_conflict <= w_conflict;
        end
    end

    assign o_busy           = r_busy;
    assign o_claim_conflict = r_conflict;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter for the register file: debug (strict priority,
// held off while its target is pending), then ALU/load round-robin. The
// winning write is registered, so it reaches the register file one cycle
// after its grant. Optional debug port: define REGFILE_ARB_DBG_EN.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    req_id_e             r_rr_ptr;
    logic                r_wr_en_p1;
    logic [ADDR_W-1:0]   r_wr_addr_p1;
    logic [DATA_W-1:0]   r_wr_data_p1;

    logic                w_dbg_grant;
    logic                w_alu_grant;
    logic                w_ld_grant;
    logic                w_any_grant;
    logic                w_clr_en;
    logic [ADDR_W-1:0]   w_clr_addr;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_data;
    logic [NUM_REGS-1:0] w_busy;

`ifdef REGFILE_ARB_DBG_EN
    // Debug may not overwrite a register that still has a writer in flight
    assign w_dbg_grant = reset & bus.dbg_valid & ~w_busy[bus.dbg_addr];
`else
    logic w_dbg_unused;
    assign w_dbg_grant  = 1'b0;
    assign w_dbg_unused = ^{bus.dbg_valid, bus.dbg_addr, bus.dbg_data};
`endif

    // ALU/load round-robin, suppressed during reset or when debug wins
    always_comb begin
        w_alu_grant = 1'b0;
        w_ld_grant  = 1'b0;
        if (reset && !w_dbg_grant) begin
            if (bus.alu_valid && bus.ld_valid) begin
                w_alu_grant = (r_rr_ptr == REQ_ALU);
                w_ld_grant  = (r_rr_ptr != REQ_ALU);
            end else begin
                w_alu_grant = bus.alu_valid;
                w_ld_grant  = bus.ld_valid;
            end
        end
    end

    // Select the winning write
    always_comb begin
        w_win_addr = bus.alu_addr;
        w_win_data = bus.alu_data;
        if (w_ld_grant) begin
            w_win_addr = bus.ld_addr;
            w_win_data = bus.ld_data;
        end
`ifdef REGFILE_ARB_DBG_EN
        if (w_dbg_grant) begin
            w_win_addr = bus.dbg_addr;
            w_win_data = bus.dbg_data;
        end
`endif
    end

    assign w_any_grant = w_alu_grant | w_ld_grant | w_dbg_grant;

    // Only architectural (ALU/load) writes retire a pending claim
    assign w_clr_en   = w_alu_grant | w_ld_grant;
    assign w_clr_addr = w_ld_grant ? bus.ld_addr : bus.alu_addr;

    // Pointer names the requester favoured on the next ALU/load tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= REQ_ALU;
        end else if (w_alu_grant) begin
            r_rr_ptr <= REQ_LD;
        end else if (w_ld_grant) begin
            r_rr_ptr <= REQ_ALU;
        end
    end

    // Output stage: write strobe every grant, address/data hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en_p1   <= 1'b0;
            r_wr_addr_p1 <= '0;
            r_wr_data_p1 <= '0;
        end else begin
            r_wr_en_p1 <= w_any_grant;
            if (w_any_grant) begin
                r_wr_addr_p1 <= w_win_addr;
                r_wr_data_p1 <= w_win_data;
            end
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk              (clk),
        .reset            (reset),
        .i_claim_en       (bus.claim_en),
        .i_claim_addr     (bus.claim_addr),
        .i_clr_en         (w_clr_en),
        .i_clr_addr       (w_clr_addr),
        .o_busy           (w_busy),
        .o_claim_conflict (bus.claim_conflict)
    );

    assign bus.alu_ready     = w_alu_grant;
    assign bus.ld_ready      = w_ld_grant;
    assign bus.dbg_ready     = w_dbg_grant;
    assign bus.rf_write_en   = r_wr_en_p1;
    assign bus.rf_write_addr = r_wr_addr_p1;
    assign bus.rf_write_data = r_wr_data_p1;
    assign bus.busy          = w_busy;
    assign bus.acc_busy      = w_busy[ACC_ADDR];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, checked against a reference model. Expected writes are queued at
// grant time and consumed by a monitor whenever the write port fires.
// Follows REGFILE_ARB_DBG_EN to decide whether the debug port is live.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

`ifdef REGFILE_ARB_DBG_EN
    localparam bit DBG_ON = 1'b1;
`else
    localparam bit DBG_ON = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    wr_t exp_q[$];

    // Reference model state
    bit  m_busy[NUM_REGS];
    int  m_turn;            // 0: ALU wins the next tie, 1: load wins
    bit  g_alu, g_ld, g_dbg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [NUM_REGS-1:0] model_busy();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
        m_turn = 0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
        bus.dbg_valid = 1'b0; bus.dbg_addr = '0; bus.dbg_data = '0;
        bus.claim_en  = 1'b0; bus.claim_addr = '0;
    endtask

    // One clock: inputs already driven at the negedge; check readies, predict,
    // then check the registered state after the edge. Ends on the next negedge.
    task automatic step();
        wr_t               w;
        bit                clr, exp_conf;
        logic [ADDR_W-1:0] clr_a;
        #1;
        g_dbg = DBG_ON && bus.dbg_valid && !m_busy[bus.dbg_addr];
        g_alu = 1'b0;
        g_ld  = 1'b0;
        if (!g_dbg) begin
            if (bus.alu_valid && bus.ld_valid) begin
                if (m_turn == 0) g_alu = 1'b1; else g_ld = 1'b1;
            end else begin
                g_alu = bus.alu_valid;
                g_ld  = bus.ld_valid;
            end
        end
        if (g_alu) m_turn = 1;
        if (g_ld)  m_turn = 0;
        chk("alu_ready", bus.alu_ready, g_alu);
        chk("ld_ready",  bus.ld_ready,  g_ld);
        chk("dbg_ready", bus.dbg_ready, g_dbg);
        if (g_dbg || g_alu || g_ld) begin
            w.addr = g_dbg ? bus.dbg_addr : (g_alu ? bus.alu_addr : bus.ld_addr);
            w.data = g_dbg ? bus.dbg_data : (g_alu ? bus.alu_data : bus.ld_data);
            w.cyc  = cyc;
            exp_q.push_back(w);
        end
        clr      = g_alu || g_ld;
        clr_a    = g_alu ? bus.alu_addr : bus.ld_addr;
        exp_conf = bus.claim_en && m_busy[bus.claim_addr] && !(clr && clr_a == bus.claim_addr);
        if (clr) m_busy[clr_a] = 1'b0;
        if (bus.claim_en) m_busy[bus.claim_addr] = 1'b1;
        @(posedge clk);
        #1;
        chk("rf_write_en",    bus.rf_write_en,    g_dbg || g_alu || g_ld);
        chk("busy",           bus.busy,           model_busy());
        chk("acc_busy",       bus.acc_busy,       m_busy[NUM_REGS-1]);
        chk("claim_conflict", bus.claim_conflict, exp_conf);
        @(negedge clk);
    endtask

    // Monitor: every write-port strobe must match the oldest queued grant
    always @(posedge clk) begin
        #1;
        if (reset === 1'b1 && bus.rf_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.rf_write_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr",    bus.rf_write_addr, e.addr);
                chk("wr_data",    bus.rf_write_data, e.data);
                chk("wr_latency", cyc, e.cyc + 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          a_act, l_act, d_act;
        logic [3:0]  order;

        // Reset state, with a request held active during reset
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 8'hA5;
        #1;
        chk("rst_alu_ready", bus.alu_ready, 1'b0);
        chk("rst_wr_en",     bus.rf_write_en, 1'b0);
        chk("rst_wr_addr",   bus.rf_write_addr, '0);
        chk("rst_wr_data",   bus.rf_write_data, '0);
        chk("rst_busy",      bus.busy, '0);
        chk("rst_conflict",  bus.claim_conflict, 1'b0);
        repeat (3) @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        step();

        // Contention straight after reset: grants alternate starting with ALU
        order = '0;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'hAA;
            bus.ld_valid  = 1'b1; bus.ld_addr  = 3'd4; bus.ld_data  = 8'h55;
            step();
            order[i] = g_alu;
        end
        chk("contention_order", order, 4'b0101);
        idle_inputs();

        // Single ALU write, then an idle cycle
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 8'h11;
        step();
        idle_inputs();
        step();
        step();

        // Scoreboard on the accumulator
        bus.claim_en = 1'b1; bus.claim_addr = 3'd7;
        step();
        idle_inputs();
        chk("sb_claim7", bus.busy, 8'h80);
        chk("sb_acc_busy", bus.acc_busy, 1'b1);
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd7; bus.alu_data = 8'h3C;
        step();
        idle_inputs();
        chk("sb_clear7", bus.busy, 8'h00);
        bus.claim_en = 1'b1; bus.claim_addr = 3'd7;
        step();
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd7; bus.alu_data = 8'h3C;
        bus.claim_en  = 1'b1; bus.claim_addr = 3'd7;
        step();
        chk("sb_claim_beats_clear", bus.busy, 8'h80);
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd7; bus.alu_data = 8'h3D;
        step();
        idle_inputs();

        // Double claim of r5 -> single-cycle conflict pulse
        bus.claim_en = 1'b1; bus.claim_addr = 3'd5;
        step();
        step();
        chk("conflict_pulse", bus.claim_conflict, 1'b1);
        idle_inputs();
        step();
        chk("conflict_gone", bus.claim_conflict, 1'b0);
        chk("busy5_held", bus.busy[5], 1'b1);

        // Debug to pending r5 waits while ALU/load proceed
        for (int i = 0; i < 2; i++) begin
            bus.dbg_valid = 1'b1; bus.dbg_addr = 3'd5; bus.dbg_data = 8'h77;
            bus.alu_valid = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'(8'h01 + i);
            bus.ld_valid  = 1'b1; bus.ld_addr  = 3'd2; bus.ld_data  = 8'(8'h02 + i);
            step();
        end
        bus.alu_valid = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_addr = 3'd5; bus.ld_data = 8'hC5;
        step();
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'h99;
        step();
        if (g_dbg) bus.dbg_valid = 1'b0;
        if (g_alu) bus.alu_valid = 1'b0;
        step();
        idle_inputs();
        step();

        // Reset asserted between a grant and its write edge
        bus.claim_en = 1'b1; bus.claim_addr = 3'd6;
        step();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 8'h5A;
        #1;
        chk("midrst_grant", bus.alu_ready, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_wr_en", bus.rf_write_en, 1'b0);
        chk("midrst_busy",  bus.busy, '0);
        chk("midrst_ready", bus.alu_ready, 1'b0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        step();
        step();

        // Random traffic; requesters hold their request until accepted
        a_act = 1'b0; l_act = 1'b0; d_act = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!a_act && $urandom_range(1, 0) == 1) begin
                a_act = 1'b1;
                bus.alu_addr = ADDR_W'($urandom); bus.alu_data = DATA_W'($urandom);
            end
            if (!l_act && $urandom_range(1, 0) == 1) begin
                l_act = 1'b1;
                bus.ld_addr = ADDR_W'($urandom); bus.ld_data = DATA_W'($urandom);
            end
            if (!d_act && $urandom_range(4, 0) == 0) begin
                d_act = 1'b1;
                bus.dbg_addr = ADDR_W'($urandom); bus.dbg_data = DATA_W'($urandom);
            end
            bus.alu_valid  = a_act;
            bus.ld_valid   = l_act;
            bus.dbg_valid  = d_act;
            bus.claim_en   = ($urandom_range(3, 0) == 0);
            bus.claim_addr = ADDR_W'($urandom);
            step();
            if (g_alu) a_act = 1'b0;
            if (g_ld)  l_act = 1'b0;
            if (g_dbg) d_act = 1'b0;
            if (!DBG_ON && d_act && $urandom_range(7, 0) == 0) d_act = 1'b0;
        end
        idle_inputs();
        step();
        step();
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Arbitrates the register file's single write port between three writeback sources: ALU result, load unit (memory data) and debug/host port. Also keeps a per-register pending-write scoreboard so the decoder can stall on read-after-write hazards. Sits between the execute/load stages and the register file write port (write_en/write_addr_in/write_data_in). It registers the winning write for one-cycle latency.

Parameters:
DATA_W, 8, register width
ADDR_W, 3, register address width
NUM_REGS, 8, number of registers (2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU writeback request
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle
ld_valid / ld_addr / ld_data / ld_ready  same as alu_*, load unit
dbg_valid / dbg_addr / dbg_data / dbg_ready  same as alu_*, debug port
claim_en  input  1  decoder issues an instruction that will write claim_addr
claim_addr  input  ADDR_W  register to mark pending
rf_write_en  output  1  to register file write_en
rf_write_addr  output  ADDR_W  to register file write_addr_in
rf_write_data  output  DATA_W  to register file write_data_in
busy  output  NUM_REGS  per-register pending-write flags
acc_busy  output  1  busy[7], accumulator hazard shortcut
claim_conflict  output  1  one-cycle pulse: claim to already-busy register

Behaviour:
- Reset (reset=0, async): rf_write_en=0, rf_write_addr=0, rf_write_data=0, busy=0, claim_conflict=0, round-robin pointer=ALU. In-flight write is dropped. Ready outputs are 0 while reset is asserted.
- Handshake: transfer occurs when valid&ready in the same cycle. Ready is combinational from valid, busy and the pointer. A requester holds valid/addr/data stable until ready is seen. Ready never rises without valid.
- Priority: debug is strict highest, but dbg_ready=0 while busy[dbg_addr]=1. Debug must never clobber a pending architectural write. When debug is blocked, ALU and load arbitrate normally.
- ALU vs load: round-robin. If both are valid, the requester not granted last wins and the pointer flips. With a single requester, it is granted and the pointer moves to the other. No requester waits more than one grant.
- At most one grant per cycle. Same-address simultaneous requests are resolved by the same rules. The loser simply waits.
- Output stage: on grant at cycle N, rf_write_en=1 and addr/data hold the winner's values at cycle N+1. With no grant, rf_write_en=0 and addr/data keep their old values. Sustained throughput is 1 write/cycle.
- Scoreboard: claim_en sets busy[claim_addr] at the next edge. A granted ALU/load write clears busy[addr] at the same edge that loads the output register. A debug grant never clears busy.
- Claim and clear on the same register in the same cycle: the claim wins and busy stays 1, because a new writer is pending.
- Claim to a register already busy (no same-cycle clear): busy stays 1 and claim_conflict pulses for 1 cycle. The decoder is required to stall instead, so this flags a decoder bug.
- acc_busy = busy[NUM_REGS-1] (accumulator is register 7), combinational.

Optional Feature:
REGFILE_ARB_DBG_EN
- Defined: the debug port operates as described above.
- Undefined: the dbg_* inputs remain in the port list but are ignored and dbg_ready is tied 0. Arbitration is pure ALU/load round-robin. No debug logic is synthesized.

Decomposition:
- Shared constants package/include cpu_pkg: DATA_W, ADDR_W, NUM_REGS, ACC_ADDR=7, requester IDs (REQ_ALU=0, REQ_LD=1, REQ_DBG=2).
- Sub-module regfile_scoreboard: busy vector, claim/clear logic, claim_conflict. The arbiter instantiates it and feeds the clear from the granted ALU/load write.

Test Plan:
- Reset mid-write: grant alu addr=3 data=0x5A, assert reset before the next edge -> rf_write_en=0, busy=0 immediately. No write appears after reset releases.
- Single ALU write: alu_valid, addr=2, data=0x11 at cycle N -> alu_ready=1 at N; rf_write_en=1, addr=2, data=0x11 at N+1; 0 at N+2.
- Contention: ALU (r1=0xAA) and load (r4=0x55) valid for 4 cycles from reset -> grants alternate ALU, LD, ALU, LD. Every grant propagates to the write port one cycle later.
- Scoreboard: claim r7 -> busy=0x80, acc_busy=1. ALU write r7=0x3C is granted -> busy=0x00 after the write edge. A claim of r7 in the same cycle as that grant leaves busy=0x80.
- Conflict: claim r5 twice in consecutive cycles with no write -> claim_conflict pulses exactly 1 cycle; busy[5]=1.
- Debug (macro defined): dbg writes r5=0x77 while busy[5]=1 -> dbg_ready=0 while ALU/load proceed. After load clears r5, dbg is granted ahead of a waiting ALU request. With the macro undefined, dbg_ready stays 0 throughout.
